// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two requesters (fetch, data), the arbiter and the
// memory controller, plus the arbiter status outputs.
interface memory_arbiter_if;
    // fetch port
    logic        f_req;
    logic [31:0] f_address;
    logic [1:0]  f_size;
    logic        f_ready;
    logic        f_valid;
    logic [31:0] f_rdata;
    logic        f_error;
    // data port
    logic        d_req;
    logic        d_write_enable;
    logic [31:0] d_address;
    logic [1:0]  d_size;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_error;
    // memory controller
    logic [31:0] mc_address;
    logic        mc_write_enable;
    logic [1:0]  mc_data_in_size;
    logic [1:0]  mc_data_out_size;
    logic [31:0] mc_data_in;
    logic [31:0] mc_data_out;
    logic        mc_memory_error;
    // status
    logic        busy;
    logic [7:0]  error_count;

    // arbiter side
    modport slave (
        input  f_req, f_address, f_size,
        output f_ready, f_valid, f_rdata, f_error,
        input  d_req, d_write_enable, d_address, d_size, d_wdata,
        output d_ready, d_valid, d_rdata, d_error,
        output mc_address, mc_write_enable, mc_data_in_size, mc_data_out_size, mc_data_in,
        input  mc_data_out, mc_memory_error,
        output busy, error_count
    );

    // requester / memory-model side
    modport master (
        output f_req, f_address, f_size,
        input  f_ready, f_valid, f_rdata, f_error,
        output d_req, d_write_enable, d_address, d_size, d_wdata,
        input  d_ready, d_valid, d_rdata, d_error,
        input  mc_address, mc_write_enable, mc_data_in_size, mc_data_out_size, mc_data_in,
        output mc_data_out, mc_memory_error,
        input  busy, error_count
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single memory controller.
// One transaction at a time: IDLE grants, ACCESS holds the request on the
// controller for WAIT_CYCLES cycles, RESP returns a one-cycle valid pulse.
module memory_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
    localparam logic       PORT_F   = 1'b0;
    localparam logic       PORT_D   = 1'b1;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  error_count_q, error_count_d;

    logic grant_f, grant_d;
    logic in_access, in_resp, last_access;

    // Winner selection: a lone requester wins, a tie goes to the port not granted last.
    // Gated with rst_n so no ready is shown while the block is held in reset.
    always_comb begin
        grant_f = rst_n && (state_q == IDLE) && bus.f_req &&
                  (!bus.d_req || (last_grant_q == PORT_D));
        grant_d = rst_n && (state_q == IDLE) && bus.d_req &&
                  (!bus.f_req || (last_grant_q == PORT_F));
    end

    // Next-state and datapath register computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        addr_d        = addr_q;
        size_d        = size_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        error_count_d = error_count_q;
        case (state_q)
            IDLE: begin
                if (grant_f || grant_d) begin
                    state_d      = ACCESS;
                    owner_d      = grant_d;
                    last_grant_d = grant_d;
                    addr_d       = grant_d ? bus.d_address : bus.f_address;
                    size_d       = grant_d ? bus.d_size    : bus.f_size;
                    we_d         = grant_d & bus.d_write_enable;
                    wdata_d      = grant_d ? bus.d_wdata   : 32'd0;
                    cnt_d        = CNT_INIT;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    err_d   = bus.mc_memory_error;
                    // writes and faulted accesses never return data
                    rdata_d = (bus.mc_memory_error || we_q) ? 32'd0 : bus.mc_data_out;
                    if (bus.mc_memory_error && (error_count_q != 8'hFF))
                        error_count_d = error_count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            owner_q       <= PORT_F;
            last_grant_q  <= PORT_D;
            addr_q        <= 32'd0;
            size_q        <= 2'd0;
            we_q          <= 1'b0;
            wdata_q       <= 32'd0;
            rdata_q       <= 32'd0;
            err_q         <= 1'b0;
            error_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
            error_count_q <= error_count_d;
        end
    end

    // Output decode from the registered state; everything idles at zero.
    always_comb begin
        in_access   = (state_q == ACCESS);
        in_resp     = (state_q == RESP);
        last_access = in_access && (cnt_q == 4'd0);

        bus.f_ready = grant_f;
        bus.d_ready = grant_d;

        bus.f_valid = in_resp && (owner_q == PORT_F);
        bus.d_valid = in_resp && (owner_q == PORT_D);
        bus.f_rdata = bus.f_valid ? rdata_q : 32'd0;
        bus.d_rdata = bus.d_valid ? rdata_q : 32'd0;
        bus.f_error = bus.f_valid & err_q;
        bus.d_error = bus.d_valid & err_q;

        bus.mc_address       = in_access ? addr_q  : 32'd0;
        bus.mc_data_in       = in_access ? wdata_q : 32'd0;
        bus.mc_data_in_size  = in_access ? size_q  : 2'd0;
        bus.mc_data_out_size = in_access ? size_q  : 2'd0;
        // a single commit strobe, on the last access cycle only
        bus.mc_write_enable  = last_access & we_q;

        bus.busy        = (state_q != IDLE);
        bus.error_count = error_count_q;
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a WAIT_CYCLES=1 instance checked through a
// scoreboard, and a WAIT_CYCLES=4 instance checked cycle by cycle.
`timescale 1ns/1ps
module tb_memory_arbiter;
    logic clk = 1'b0;
    logic rst1_n;
    logic rst4_n;
    always #5 clk = ~clk;

    memory_arbiter_if b1 ();
    memory_arbiter_if b4 ();

    memory_arbiter #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(b1));
    memory_arbiter #(.WAIT_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(b4));

    // memory model: fixed pattern, 0x10 holds 0xDEADBEEF; 0x300 and size 11 fault
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction
    function automatic logic mem_err(input logic [31:0] a, input logic [1:0] s);
        return (a == 32'h300) || (s == 2'b11);
    endfunction

    assign b1.mc_data_out     = mem_rd(b1.mc_address);
    assign b1.mc_memory_error = mem_err(b1.mc_address, b1.mc_data_in_size);
    assign b4.mc_data_out     = mem_rd(b4.mc_address);
    assign b4.mc_memory_error = mem_err(b4.mc_address, b4.mc_data_in_size);

    int checks = 0;
    int passes = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          gcyc;
    } exp_t;

    exp_t sb1[$];
    logic gl[$];
    int   gcl[$];
    exp_t e_mon;

    // Scoreboard monitor for the W=1 instance: push at grant, check in ACCESS, pop at valid.
    always @(negedge clk) begin
        #2;
        if (rst1_n) begin
            if (b1.f_ready || b1.d_ready) begin
                check_val("one_ready", {31'd0, b1.f_ready & b1.d_ready}, 32'd0);
                e_mon.port  = b1.d_ready;
                e_mon.addr  = b1.d_ready ? b1.d_address : b1.f_address;
                e_mon.size  = b1.d_ready ? b1.d_size : b1.f_size;
                e_mon.we    = b1.d_ready & b1.d_write_enable;
                e_mon.wdata = b1.d_ready ? b1.d_wdata : 32'd0;
                e_mon.err   = mem_err(e_mon.addr, e_mon.size);
                e_mon.rdata = (e_mon.we || e_mon.err) ? 32'd0 : mem_rd(e_mon.addr);
                e_mon.gcyc  = cyc;
                sb1.push_back(e_mon);
                gl.push_back(e_mon.port);
                gcl.push_back(cyc);
            end
            if (b1.busy && !b1.f_valid && !b1.d_valid) begin
                if (sb1.size() == 0) check_val("access_no_txn", 32'd1, 32'd0);
                else begin
                    check_val("mc_address", b1.mc_address, sb1[0].addr);
                    check_val("mc_in_size", {30'd0, b1.mc_data_in_size}, {30'd0, sb1[0].size});
                    check_val("mc_out_size", {30'd0, b1.mc_data_out_size}, {30'd0, sb1[0].size});
                    check_val("mc_data_in", b1.mc_data_in, sb1[0].wdata);
                    check_val("mc_we", {31'd0, b1.mc_write_enable}, {31'd0, sb1[0].we});
                    check_val("access_cycle", cyc, sb1[0].gcyc + 1);
                end
            end else begin
                check_val("mc_we_idle", {31'd0, b1.mc_write_enable}, 32'd0);
                check_val("mc_addr_idle", b1.mc_address, 32'd0);
            end
            if (b1.f_valid || b1.d_valid) begin
                if (sb1.size() == 0) check_val("unexpected_valid", 32'd1, 32'd0);
                else begin
                    e_mon = sb1.pop_front();
                    check_val("valid_port", {30'd0, b1.f_valid, b1.d_valid},
                              e_mon.port ? 32'd1 : 32'd2);
                    check_val("rdata", e_mon.port ? b1.d_rdata : b1.f_rdata, e_mon.rdata);
                    check_val("error", {31'd0, e_mon.port ? b1.d_error : b1.f_error},
                              {31'd0, e_mon.err});
                    check_val("other_rdata", e_mon.port ? b1.f_rdata : b1.d_rdata, 32'd0);
                    check_val("other_error", {31'd0, e_mon.port ? b1.f_error : b1.d_error}, 32'd0);
                    check_val("valid_latency", cyc, e_mon.gcyc + 2);
                end
            end
        end
    end

    // One request on the W=1 instance: wait for its grant, drop req, wait for IDLE.
    task automatic txn1(input logic port, input logic [31:0] addr, input logic [1:0] size,
                        input logic we, input logic [31:0] wdata);
        bit got;
        got = 1'b0;
        @(negedge clk);
        if (port) begin
            b1.d_req = 1'b1; b1.d_address = addr; b1.d_size = size;
            b1.d_write_enable = we; b1.d_wdata = wdata;
        end else begin
            b1.f_req = 1'b1; b1.f_address = addr; b1.f_size = size;
        end
        for (int i = 0; i < 20; i++) begin
            #3;
            if (port ? b1.d_ready : b1.f_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check_val("grant_timeout", 32'd0, 32'd1);
        @(negedge clk);
        b1.f_req = 1'b0;
        b1.d_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #3;
            if (!b1.busy) break;
            @(negedge clk);
        end
    endtask

    initial begin
        rst1_n = 1'b0; rst4_n = 1'b0;
        b1.f_req = 1'b0; b1.f_address = 32'd0; b1.f_size = 2'd0;
        b1.d_req = 1'b0; b1.d_write_enable = 1'b0; b1.d_address = 32'd0;
        b1.d_size = 2'd0; b1.d_wdata = 32'd0;
        b4.f_req = 1'b0; b4.f_address = 32'd0; b4.f_size = 2'd0;
        b4.d_req = 1'b0; b4.d_write_enable = 1'b0; b4.d_address = 32'd0;
        b4.d_size = 2'd0; b4.d_wdata = 32'd0;

        // reset state with requests pending
        repeat (2) @(negedge clk);
        b1.f_req = 1'b1; b1.d_req = 1'b1;
        #3;
        check_val("rst_f_ready", {31'd0, b1.f_ready}, 32'd0);
        check_val("rst_d_ready", {31'd0, b1.d_ready}, 32'd0);
        check_val("rst_busy", {31'd0, b1.busy}, 32'd0);
        check_val("rst_err_cnt", {24'd0, b1.error_count}, 32'd0);
        check_val("rst_mc_we", {31'd0, b1.mc_write_enable}, 32'd0);
        check_val("rst_valid", {30'd0, b1.f_valid, b1.d_valid}, 32'd0);
        @(negedge clk);
        b1.f_req = 1'b0; b1.d_req = 1'b0;
        rst1_n = 1'b1; rst4_n = 1'b1;

        // W=1 single transactions
        txn1(1'b0, 32'h10, 2'b10, 1'b0, 32'd0);
        txn1(1'b1, 32'h100, 2'b10, 1'b1, 32'h12345678);
        txn1(1'b1, 32'h104, 2'b01, 1'b0, 32'd0);
        txn1(1'b0, 32'h80, 2'b00, 1'b0, 32'd0);
        txn1(1'b1, 32'h300, 2'b10, 1'b0, 32'd0);
        check_val("err_cnt_1", {24'd0, b1.error_count}, 32'd1);
        txn1(1'b1, 32'h44, 2'b11, 1'b0, 32'd0);
        check_val("err_cnt_2", {24'd0, b1.error_count}, 32'd2);

        // both requesters held: last grant was data, so F, D, F, D every 3 cycles
        gl.delete(); gcl.delete();
        @(negedge clk);
        b1.f_req = 1'b1; b1.f_address = 32'h20; b1.f_size = 2'b10;
        b1.d_req = 1'b1; b1.d_address = 32'h24; b1.d_size = 2'b10;
        b1.d_write_enable = 1'b0; b1.d_wdata = 32'd0;
        for (int i = 0; i < 40; i++) begin
            #3;
            if (gl.size() >= 4) break;
            @(negedge clk);
        end
        @(negedge clk);
        b1.f_req = 1'b0; b1.d_req = 1'b0;
        if (gl.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check_val($sformatf("tie_grant%0d", k), {31'd0, gl[k]}, (k % 2 == 1) ? 32'd1 : 32'd0);
                if (k > 0) check_val($sformatf("tie_gap%0d", k), gcl[k] - gcl[k-1], 32'd3);
            end
        end else begin
            check_val("tie_grants", gl.size(), 32'd4);
        end
        repeat (4) @(negedge clk);

        // saturation of the error counter
        for (int k = 0; k < 300; k++) begin
            txn1(1'b1, 32'h300, 2'b10, 1'b0, 32'd0);
            if (k == 251) check_val("err_cnt_254", {24'd0, b1.error_count}, 32'd254);
        end
        check_val("err_cnt_sat", {24'd0, b1.error_count}, 32'd255);
        check_val("sb_empty", sb1.size(), 32'd0);

        // W=4 write: ACCESS cycles 1..4, commit on cycle 4, valid on cycle 5
        @(negedge clk);
        b4.d_req = 1'b1; b4.d_address = 32'h100; b4.d_size = 2'b10;
        b4.d_write_enable = 1'b1; b4.d_wdata = 32'hA5A50F0F;
        #3;
        check_val("w4_d_ready", {31'd0, b4.d_ready}, 32'd1);
        check_val("w4_f_ready", {31'd0, b4.f_ready}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) b4.d_req = 1'b0;
            #3;
            if (k <= 4) begin
                check_val($sformatf("w4_addr_c%0d", k), b4.mc_address, 32'h100);
                check_val($sformatf("w4_wdata_c%0d", k), b4.mc_data_in, 32'hA5A50F0F);
                check_val($sformatf("w4_we_c%0d", k), {31'd0, b4.mc_write_enable}, (k == 4) ? 32'd1 : 32'd0);
                check_val($sformatf("w4_valid_c%0d", k), {31'd0, b4.d_valid}, 32'd0);
            end else begin
                check_val("w4_valid_c5", {30'd0, b4.f_valid, b4.d_valid}, 32'd1);
                check_val("w4_rdata_c5", b4.d_rdata, 32'd0);
                check_val("w4_error_c5", {31'd0, b4.d_error}, 32'd0);
                check_val("w4_we_c5", {31'd0, b4.mc_write_enable}, 32'd0);
                check_val("w4_addr_c5", b4.mc_address, 32'd0);
            end
        end
        @(negedge clk); #3;
        check_val("w4_idle", {31'd0, b4.busy}, 32'd0);

        // W=4 write aborted by reset in its first ACCESS cycle
        @(negedge clk);
        b4.d_req = 1'b1; b4.d_address = 32'h200; b4.d_write_enable = 1'b1; b4.d_wdata = 32'h55AA55AA;
        #3;
        check_val("abort_grant", {31'd0, b4.d_ready}, 32'd1);
        @(negedge clk);
        b4.d_req = 1'b0;
        #1;
        rst4_n = 1'b0;
        #1;
        check_val("abort_busy", {31'd0, b4.busy}, 32'd0);
        check_val("abort_addr", b4.mc_address, 32'd0);
        b4.f_req = 1'b1; b4.f_address = 32'h10; b4.f_size = 2'b10;
        b4.d_req = 1'b1; b4.d_address = 32'h104; b4.d_write_enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #3;
            check_val($sformatf("abort_we%0d", k), {31'd0, b4.mc_write_enable}, 32'd0);
            check_val($sformatf("abort_valid%0d", k), {30'd0, b4.f_valid, b4.d_valid}, 32'd0);
            check_val($sformatf("abort_ready%0d", k), {30'd0, b4.f_ready, b4.d_ready}, 32'd0);
        end
        @(negedge clk);
        rst4_n = 1'b1;
        #3;
        check_val("post_rst_f_ready", {31'd0, b4.f_ready}, 32'd1);
        check_val("post_rst_d_ready", {31'd0, b4.d_ready}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin b4.f_req = 1'b0; b4.d_req = 1'b0; end
            #3;
            check_val($sformatf("post_rst_we%0d", k), {31'd0, b4.mc_write_enable}, 32'd0);
            if (k == 5) begin
                check_val("post_rst_valid", {30'd0, b4.f_valid, b4.d_valid}, 32'd2);
                check_val("post_rst_rdata", b4.f_rdata, 32'hDEADBEEF);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning the number of ACCESS cycles per transaction (legal range 1..15).
REQ-002 SHALL have ports `clk` (in, 1, sole clock, rising edge) and `rst_n` (in, 1, asynchronous active-low reset).
REQ-003 SHALL have fetch-port inputs: `f_req` (1, request), `f_address` (32), `f_size` (2; 00 byte, 01 half, 10 word).
REQ-004 SHALL have fetch-port outputs: `f_ready` (1, grant), `f_valid` (1, response), `f_rdata` (32), `f_error` (1).
REQ-005 SHALL have data-port inputs: `d_req` (1), `d_write_enable` (1), `d_address` (32), `d_size` (2), `d_wdata` (32).
REQ-006 SHALL have data-port outputs: `d_ready` (1), `d_valid` (1), `d_rdata` (32), `d_error` (1).
REQ-007 SHALL have memory-controller outputs: `mc_address` (32), `mc_write_enable` (1), `mc_data_in_size` (2), `mc_data_out_size` (2), `mc_data_in` (32).
REQ-008 SHALL have memory-controller inputs: `mc_data_out` (32, read data) and `mc_memory_error` (1).
REQ-009 SHALL have status outputs: `busy` (1, state not IDLE) and `error_count` (8, saturating count of errored transactions).

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS and RESP, each transition taken on a rising `clk` edge.
REQ-011 IDLE: with any req high, SHALL select a winner, latch its address/size/write-enable/wdata (fetch write-enable = 0, fetch wdata = 0), load wait counter = WAIT_CYCLES-1, and go to ACCESS.
REQ-012 `f_ready`/`d_ready` SHALL be combinational, high only in IDLE for the selected winner; the requester may drop req after the ready cycle.
REQ-013 Arbitration: single requester wins; if both request, the port not granted last wins; the last-grant register resets to "data", so fetch wins the first tie.
REQ-014 Requests SHALL be sampled only in IDLE; req in ACCESS/RESP is ignored until IDLE returns.
REQ-015 ACCESS: `mc_address`, `mc_data_in`, `mc_data_in_size` and `mc_data_out_size` SHALL equal the latched values; both size outputs carry the same latched size.
REQ-016 ACCESS: counter decrements each cycle; at counter == 0, SHALL register `mc_data_out` and `mc_memory_error` into response registers and go to RESP.
REQ-017 `mc_write_enable` SHALL be high only in the final ACCESS cycle (counter == 0) of a latched write, giving exactly one commit per write.
REQ-018 Outside ACCESS, all mc_* outputs SHALL be driven to 0.
REQ-019 RESP: owner's valid SHALL be high for exactly one cycle with rdata/error from the response registers; the other port's valid stays 0; next state is IDLE.
REQ-020 Writes SHALL return rdata 0; errored transactions SHALL return rdata 0 and error 1.
REQ-021 Non-owner rdata/error and all ports outside RESP SHALL read 0.
REQ-022 Latency: ready cycle = T; ACCESS = T+1..T+WAIT_CYCLES; valid = T+WAIT_CYCLES+1; next grant earliest at T+WAIT_CYCLES+2.
REQ-023 `error_count` SHALL increment by 1 on each transaction that enters RESP with error set, saturating at 255.
REQ-024 The block SHALL not check size or alignment itself; size 11 and range faults SHALL be reported solely through `mc_memory_error`.

Reset
REQ-025 When `rst_n` is low, the block SHALL immediately enter IDLE and clear all registers: latched request, counter, response, `error_count`, last-grant = data.
REQ-026 During reset, all outputs SHALL be 0, including `mc_write_enable`.
REQ-027 Reset mid-transaction SHALL drop the transaction with no valid pulse and no write commit.
REQ-028 After `rst_n` deasserts, the first IDLE cycle SHALL accept requests.

Verification
REQ-029 Fetch read, W=1: f_req, addr 0x10, size 10, mc_data_out 0xDEADBEEF -> f_ready cycle 0; mc_address 0x10 cycle 1; f_valid cycle 2 with f_rdata 0xDEADBEEF, f_error 0.
REQ-030 Data write, W=1: addr 0x100, size 10, wdata 0x12345678 -> mc_write_enable high cycle 1 only; d_valid cycle 2 with d_rdata 0, d_error 0.
REQ-031 Both reqs held continuously -> grants F, D, F, D with one grant every 3 cycles, and each valid on the matching port only.
REQ-032 Data read, addr 0x300, mc_memory_error 1 -> d_valid with d_error 1, d_rdata 0, error_count 0->1; after 300 errors, error_count holds 255.
REQ-033 W=4, data write -> mc_address valid for cycles 1-4; mc_write_enable high cycle 4 only; d_valid cycle 5.
REQ-034 rst_n low in cycle 1 of a write (W=4) -> mc_write_enable stays 0 and no valid; after release, simultaneous reqs grant fetch first.
